multicycle_control: RTL and testbench

Multicycle MIPS main control FSM; the producer side of the ALUOp interface, sitting upstream of the ALU control decoder. Sequences each instruction through fetch/decode/execute/memory/write-back and drives datapath muxes, write-enables and the 3-bit ALUOp code. Supports an optional memory-ready handshake and keeps a retired-instruction counter.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/multicycle_control_opcode_class.sv | 23 ++
 rtl/multicycle_control.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
package mc_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_I_EXEC,
        S_I_WB,
        S_BRANCH,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_IMM,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALUOP_RTYPE = 3'b111;
    localparam logic [2:0] ALUOP_ADD   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_IDLE  = 3'b000;

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Opcode/Funct to instruction class; JR is an R-format opcode
// but sequences as a jump.
module mc_opcode_class
    import mc_pkg::*;
(
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    output iclass_t    cls_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        unique case (Opcode)
            OP_R:            cls_o = (Funct == FUNCT_JR) ? CLS_JUMP : CLS_R;
            OP_ADDI, OP_ORI: cls_o = CLS_IMM;
            OP_LW, OP_SW:    cls_o = CLS_MEM;
            OP_BEQ, OP_BNE:  cls_o = CLS_BRANCH;
            OP_J, OP_JAL:    cls_o = CLS_JUMP;
            default:         cls_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with retire counter.
// Build option: MULTICYCLE_MEM_HANDSHAKE_EN stalls memory states on MemReady.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int COUNT_W         = 16,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               PCWrite,
    output logic               InstrDone,
    output logic [COUNT_W-1:0] InstrCount,
    output logic               IllegalOp
);

    state_t               state_q, state_d;
    logic [COUNT_W-1:0]   cnt_q;
    iclass_t              cls;
    logic                 mem_rdy;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    assign mem_rdy = MemReady;
`else
    assign mem_rdy = MemReady | 1'b1;
`endif

    mc_opcode_class u_class (
        .Opcode (Opcode),
        .Funct  (Funct),
        .cls_o  (cls)
    );

    always_comb begin
        state_d   = state_q;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 2'b00;
        MemtoReg  = 2'b00;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = ALUOP_IDLE;
        PCSource  = 2'b00;
        PCWrite   = 1'b0;
        InstrDone = 1'b0;
        IllegalOp = 1'b0;
        unique case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ALUOP_ADD;
                IRWrite = mem_rdy;
                PCWrite = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ALUOP_ADD;
                unique case (cls)
                    CLS_R:      state_d = S_R_EXEC;
                    CLS_IMM:    state_d = S_I_EXEC;
                    CLS_MEM:    state_d = S_MEM_ADDR;
                    CLS_BRANCH: state_d = S_BRANCH;
                    CLS_JUMP:   state_d = S_JUMP;
                    default:    state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALUOP_ADD;
                state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_rdy) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'b01;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_RTYPE;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite  = 1'b1;
                RegDst    = 2'b01;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = (Opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_SUB;
                PCSource  = 2'b01;
                PCWrite   = (Opcode == OP_BNE) ? ~Zero : Zero;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                PCWrite   = 1'b1;
                PCSource  = (Opcode == OP_R) ? 2'b11 : 2'b10;
                InstrDone = 1'b1;
                state_d   = S_FETCH;
                // JAL links the return address into $ra
                if (Opcode == OP_JAL) begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
            end
            S_ILLEGAL: begin
                IllegalOp = 1'b1;
                if (HALT_ON_ILLEGAL == 0) state_d = S_FETCH;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (InstrDone) cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign InstrCount = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class,
// illegal halt/no-halt, mid-instruction reset, counter wrap and MemReady stalls.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Funct = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b1;

    logic        IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0]  ALUOp;
    logic        PCWrite, InstrDone, IllegalOp;
    logic [3:0]  InstrCount;

    logic        IorD_n, MemRead_n, MemWrite_n, IRWrite_n, RegWrite_n;
    logic        ALUSrcA_n, PCWrite_n, InstrDone_n, IllegalOp_n;
    logic [1:0]  RegDst_n, MemtoReg_n, ALUSrcB_n, PCSource_n;
    logic [2:0]  ALUOp_n;
    logic [15:0] InstrCount_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_control #(.COUNT_W(4), .HALT_ON_ILLEGAL(1)) u_dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .MemReady(MemReady), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .PCWrite(PCWrite), .InstrDone(InstrDone),
        .InstrCount(InstrCount), .IllegalOp(IllegalOp)
    );

    multicycle_control #(.COUNT_W(16), .HALT_ON_ILLEGAL(0)) u_dut_nh (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
        .Zero(Zero), .MemReady(MemReady), .IorD(IorD_n),
        .MemRead(MemRead_n), .MemWrite(MemWrite_n), .IRWrite(IRWrite_n),
        .RegDst(RegDst_n), .MemtoReg(MemtoReg_n), .RegWrite(RegWrite_n),
        .ALUSrcA(ALUSrcA_n), .ALUSrcB(ALUSrcB_n), .ALUOp(ALUOp_n),
        .PCSource(PCSource_n), .PCWrite(PCWrite_n),
        .InstrDone(InstrDone_n), .InstrCount(InstrCount_n),
        .IllegalOp(IllegalOp_n)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cv(
        input int iord, input int mr, input int mw, input int irw,
        input int rd, input int m2r, input int rw, input int sa,
        input int sb, input int aop, input int ps, input int pcw,
        input int done, input int ill);
        return {12'b0, 1'(iord), 1'(mr), 1'(mw), 1'(irw), 2'(rd),
                2'(m2r), 1'(rw), 1'(sa), 2'(sb), 3'(aop), 2'(ps),
                1'(pcw), 1'(done), 1'(ill)};
    endfunction

    function automatic logic [31:0] ctl();
        return {12'b0, IorD, MemRead, MemWrite, IRWrite, RegDst,
                MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                PCWrite, InstrDone, IllegalOp};
    endfunction

    logic [31:0] C_FETCH, C_DEC, C_REX, C_RWB, C_MADDR, C_MRD, C_MWB;
    logic [31:0] C_MWR, C_IEXA, C_IEXO, C_IWB, C_J, C_JAL, C_JR, C_ILL;
    logic [31:0] C_FSTALL, C_WSTALL;

    task automatic step(input string tag, input logic [31:0] exp);
        @(posedge clk);
        #1;
        check(tag, ctl(), exp);
    endtask

    task automatic issue(input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Funct  = fn;
        step("decode", C_DEC);
    endtask

    localparam logic [5:0] BR_OP [4] = '{6'b000100, 6'b000100,
                                        6'b000101, 6'b000101};
    localparam bit BR_Z   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam bit BR_PCW [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        C_FETCH  = cv(0,1,0,1, 0,0,0,0, 1,4,0,1, 0,0);
        C_FSTALL = cv(0,1,0,0, 0,0,0,0, 1,4,0,0, 0,0);
        C_DEC    = cv(0,0,0,0, 0,0,0,0, 3,4,0,0, 0,0);
        C_REX    = cv(0,0,0,0, 0,0,0,1, 0,7,0,0, 0,0);
        C_RWB    = cv(0,0,0,0, 1,0,1,0, 0,0,0,0, 1,0);
        C_MADDR  = cv(0,0,0,0, 0,0,0,1, 2,4,0,0, 0,0);
        C_MRD    = cv(1,1,0,0, 0,0,0,0, 0,0,0,0, 0,0);
        C_MWB    = cv(0,0,0,0, 0,1,1,0, 0,0,0,0, 1,0);
        C_MWR    = cv(1,0,1,0, 0,0,0,0, 0,0,0,0, 1,0);
        C_WSTALL = cv(1,0,1,0, 0,0,0,0, 0,0,0,0, 0,0);
        C_IEXA   = cv(0,0,0,0, 0,0,0,1, 2,4,0,0, 0,0);
        C_IEXO   = cv(0,0,0,0, 0,0,0,1, 2,5,0,0, 0,0);
        C_IWB    = cv(0,0,0,0, 0,0,1,0, 0,0,0,0, 1,0);
        C_J      = cv(0,0,0,0, 0,0,0,0, 0,0,2,1, 1,0);
        C_JAL    = cv(0,0,0,0, 2,2,1,0, 0,0,2,1, 1,0);
        C_JR     = cv(0,0,0,0, 0,0,0,0, 0,0,3,1, 1,0);
        C_ILL    = cv(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", ctl(), 32'h0);
        check("reset_cnt", 32'(InstrCount), 32'd0);
        reset = 1'b0;
        step("fetch0", C_FETCH);

        issue(6'b000000, 6'b100000);
        step("r_exec", C_REX);
        step("r_wb", C_RWB);
        step("fetch", C_FETCH);
        check("cnt_add", 32'(InstrCount), 32'd1);

        for (int i = 0; i < 4; i++) begin
            Zero = BR_Z[i];
            issue(BR_OP[i], 6'b0);
            step($sformatf("branch%0d", i),
                 cv(0,0,0,0, 0,0,0,1, 0,6,1,int'(BR_PCW[i]), 1,0));
            step("fetch", C_FETCH);
        end
        check("cnt_br", 32'(InstrCount), 32'd5);

        issue(6'b100011, 6'b0);
        step("lw_addr", C_MADDR);
        step("lw_read", C_MRD);
        step("lw_wb", C_MWB);
        step("fetch", C_FETCH);
        issue(6'b101011, 6'b0);
        step("sw_addr", C_MADDR);
        step("sw_write", C_MWR);
        step("sw_fetch", C_FETCH);
        check("cnt_mem", 32'(InstrCount), 32'd7);

        issue(6'b001000, 6'b0);
        step("addi_ex", C_IEXA);
        step("addi_wb", C_IWB);
        step("fetch", C_FETCH);
        issue(6'b001101, 6'b0);
        step("ori_ex", C_IEXO);
        step("ori_wb", C_IWB);
        step("fetch", C_FETCH);

        issue(6'b000010, 6'b0);
        step("j", C_J);
        step("fetch", C_FETCH);
        issue(6'b000011, 6'b0);
        step("jal", C_JAL);
        step("fetch", C_FETCH);
        issue(6'b000000, 6'b001000);
        step("jr", C_JR);
        step("fetch", C_FETCH);
        check("cnt_jmp", 32'(InstrCount), 32'd12);

        for (int i = 0; i < 4; i++) begin
            issue(6'b000010, 6'b0);
            step("j_wrap", C_J);
            step("fetch", C_FETCH);
            if (i == 2) check("cnt_15", 32'(InstrCount), 32'd15);
        end
        check("cnt_wrap", 32'(InstrCount), 32'd0);

        issue(6'b111111, 6'b0);
        step("illegal", C_ILL);
        check("nh_illegal", 32'(IllegalOp_n), 32'd1);
        step("illegal_hold", C_ILL);
        check("nh_fetch", {30'b0, MemRead_n, IllegalOp_n}, 32'd2);
        step("illegal_hold2", C_ILL);
        step("illegal_hold3", C_ILL);
        check("cnt_illegal", 32'(InstrCount), 32'd0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset2_ctl", ctl(), 32'h0);
        reset = 1'b0;
        step("fetch_r2", C_FETCH);
        issue(6'b101011, 6'b0);
        step("sw2_addr", C_MADDR);
        step("sw2_write", C_MWR);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ctl", ctl(), 32'h0);
        check("midrst_memwrite", 32'(MemWrite), 32'd0);
        check("midrst_cnt", 32'(InstrCount), 32'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        MemReady = 1'b0;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        step("fstall1", C_FSTALL);
        step("fstall2", C_FSTALL);
        step("fstall3", C_FSTALL);
        step("fstall4", C_FSTALL);
        MemReady = 1'b1;
        #1;
        check("fstall_go", ctl(), C_FETCH);
        issue(6'b101011, 6'b0);
        MemReady = 1'b0;
        step("hs_addr", C_MADDR);
        step("wstall1", C_WSTALL);
        step("wstall2", C_WSTALL);
        step("wstall3", C_WSTALL);
        MemReady = 1'b1;
        #1;
        check("wstall_go", ctl(), C_MWR);
`else
        step("fetch_nohs", C_FETCH);
        issue(6'b101011, 6'b0);
        step("nohs_addr", C_MADDR);
        step("nohs_write", C_MWR);
`endif
        step("hs_fetch", C_FETCH);
        check("cnt_hs", 32'(InstrCount), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
